pixel_fetch: RTL and testbench

//  Consumes the memory-address stream produced by the pixel-mapping stage's address FIFO and

---
 rtl/pixel_fetch.sv | 167 ++++++++++++++++
 tb/tb_pixel_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// -----------------------------------------------------------------------------
// pixel_fetch
//
// Pops pixel addresses from the pixel-mapping stage's address FIFO, reads each
// addressed pixel from frame SRAM and hands the pixels, in order, to the
// display output stage through a small circular output buffer.
// An entry whose valid flag is clear yields BLANK_COLOUR without touching SRAM.
// Only one fetch is ever in flight. Its buffer slot is reserved before the
// address is popped, so a finished fetch always finds room in the buffer.
//
// Parameters
//   READ_LATENCY  cycles from an accepted SRAM request to iMEM_DATA valid (1..15)
//   OUT_DEPTH     output buffer depth, power of two, at least 2
//   BLANK_COLOUR  pixel emitted for an entry whose valid flag is clear
//
// Ports
//   CLK         in   1   clock
//   RESET_N     in   1   asynchronous active-low reset
//   iADDRESS    in   20  address FIFO data: [19] valid flag, [18:0] pixel address
//   iREADY_N    in   1   address FIFO empty flag (low = entry available)
//   oREAD       out  1   address FIFO read request (non-showahead FIFO)
//   oMEM_REQ    out  1   SRAM read request to the arbiter
//   oMEM_ADDR   out  19  SRAM read address
//   iMEM_GNT    in   1   arbiter grant; request accepted when oMEM_REQ && iMEM_GNT
//   iMEM_DATA   in   16  SRAM read data
//   oPIX_DATA   out  16  buffer head pixel
//   oPIX_VALID  out  1   buffer not empty
//   iPIX_READY  in   1   display stage ready; transfer when oPIX_VALID && iPIX_READY
// -----------------------------------------------------------------------------
module pixel_fetch #(
    parameter int          READ_LATENCY = 2,
    parameter int          OUT_DEPTH    = 4,
    parameter logic [15:0] BLANK_COLOUR = 16'h0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [19:0] iADDRESS,
    input  logic        iREADY_N,
    output logic        oREAD,
    output logic        oMEM_REQ,
    output logic [18:0] oMEM_ADDR,
    input  logic        iMEM_GNT,
    input  logic [15:0] iMEM_DATA,
    output logic [15:0] oPIX_DATA,
    output logic        oPIX_VALID,
    input  logic        iPIX_READY
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
    localparam logic [3:0]       LAT_LOAD = 4'(READ_LATENCY - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_PUSH  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [18:0]      pending_addr;
    logic [15:0]      fetch_data;
    logic [3:0]       lat_cnt;

    logic [15:0]      buf_mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             buf_push;
    logic             buf_pop;
    logic             slot_free;

    // ---------------------------------------------------------------------
    // Fetch sequencer
    // ---------------------------------------------------------------------
    // Checking count here is what reserves the slot: nothing else can be
    // pushed until this fetch reaches PUSH, and pops only free space.
    assign slot_free = (count < DEPTH_C);

    always_comb begin
        // NOTE: default assignment first so every path assigns state_nxt and
        // no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (!iREADY_N && slot_free) state_nxt = S_POP;
            S_POP:   state_nxt = S_LATCH;
            S_LATCH: state_nxt = iADDRESS[19] ? S_REQ : S_PUSH;
            S_REQ:   if (iMEM_GNT) state_nxt = S_WAIT;
            S_WAIT:  if (lat_cnt == 4'd0) state_nxt = S_PUSH;
            S_PUSH:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state is always updated with non-blocking
        // assignments so every flop samples pre-edge values.
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_addr <= '0;
            fetch_data   <= '0;
            lat_cnt      <= '0;
        end else begin
            case (state)
                S_LATCH: begin
                    // FIFO data is valid the cycle after the oREAD pulse.
                    pending_addr <= iADDRESS[18:0];
                    if (!iADDRESS[19]) fetch_data <= BLANK_COLOUR;
                end
                S_REQ: begin
                    if (iMEM_GNT) lat_cnt <= LAT_LOAD;
                end
                S_WAIT: begin
                    // WAIT lasts READ_LATENCY cycles; the last one carries data.
                    if (lat_cnt == 4'd0) fetch_data <= iMEM_DATA;
                    else                 lat_cnt    <= lat_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Control outputs are pure state decodes, so they drop with reset at once.
    assign oREAD     = (state == S_POP);
    assign oMEM_REQ  = (state == S_REQ);
    assign oMEM_ADDR = pending_addr;

    // ---------------------------------------------------------------------
    // Output buffer: circular FIFO, pointers wrap naturally at OUT_DEPTH
    // ---------------------------------------------------------------------
    assign buf_push = (state == S_PUSH);
    assign buf_pop  = oPIX_VALID && iPIX_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is a handful of flops, and clearing it keeps
            // oPIX_DATA at zero out of reset instead of showing stale pixels.
            for (int i = 0; i < OUT_DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            if (buf_push) begin
                buf_mem[wr_ptr] <= fetch_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (buf_pop) rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave the count unchanged.
            case ({buf_push, buf_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign oPIX_VALID = (count != '0);
    assign oPIX_DATA  = buf_mem[rd_ptr];

endmodule

// File: tb/tb_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_pixel_fetch
//
// Directed bench for pixel_fetch. The surroundings are modelled here: a
// non-showahead address FIFO, an SRAM that returns data exactly READ_LATENCY
// cycles after a grant (and 16'hDEAD on every other cycle), and a display sink
// that logs every transfer. Inputs change 1 time unit after the rising edge;
// outputs are checked there and transfers are logged on the falling edge.
// -----------------------------------------------------------------------------
module tb_pixel_fetch;

    localparam int          TB_RL  = 2;
    localparam logic [19:0] POISON = 20'hFFFFF;

    logic        CLK        = 1'b0;
    logic        RESET_N    = 1'b0;
    logic [19:0] iADDRESS   = POISON;
    logic        iREADY_N   = 1'b1;
    logic        oREAD;
    logic        oMEM_REQ;
    logic [18:0] oMEM_ADDR;
    logic        iMEM_GNT   = 1'b1;
    logic [15:0] iMEM_DATA;
    logic [15:0] oPIX_DATA;
    logic        oPIX_VALID;
    logic        iPIX_READY = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int read_cnt = 0;
    int req_cyc  = 0;
    int underflow = 0;

    logic [19:0] fifo_q [$];
    logic [15:0] exp_q  [$];
    logic [15:0] rx_q   [$];

    logic        pipe_v [TB_RL];
    logic [18:0] pipe_a [TB_RL];

    pixel_fetch #(
        .READ_LATENCY(TB_RL),
        .OUT_DEPTH   (4),
        .BLANK_COLOUR(16'h0)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .iADDRESS  (iADDRESS),
        .iREADY_N  (iREADY_N),
        .oREAD     (oREAD),
        .oMEM_REQ  (oMEM_REQ),
        .oMEM_ADDR (oMEM_ADDR),
        .iMEM_GNT  (iMEM_GNT),
        .iMEM_DATA (iMEM_DATA),
        .oPIX_DATA (oPIX_DATA),
        .oPIX_VALID(oPIX_VALID),
        .iPIX_READY(iPIX_READY)
    );

    always #5 CLK = ~CLK;

    // Frame SRAM contents as seen by the bench.
    function automatic logic [15:0] sram_val(input logic [18:0] a);
        if (a == 19'd1234) return 16'hABCD;
        return a[15:0] ^ 16'h3C3C;
    endfunction

    // Non-showahead address FIFO: data appears the cycle after oREAD, and is
    // poisoned otherwise so a mistimed capture shows up.
    always @(posedge CLK) begin
        if (oREAD) begin
            if (fifo_q.size() != 0) iADDRESS <= fifo_q.pop_front();
            else                    underflow <= underflow + 1;
        end else begin
            iADDRESS <= POISON;
        end
        iREADY_N <= (fifo_q.size() == 0);
    end

    // SRAM: read data valid only READ_LATENCY cycles after an accepted request.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < TB_RL; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= oMEM_REQ && iMEM_GNT;
            pipe_a[0] <= oMEM_ADDR;
            for (int i = 1; i < TB_RL; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end
    assign iMEM_DATA = pipe_v[TB_RL-1] ? sram_val(pipe_a[TB_RL-1]) : 16'hDEAD;

    // Display sink and activity counters.
    always @(negedge CLK) begin
        if (oPIX_VALID && iPIX_READY) rx_q.push_back(oPIX_DATA);
        if (oREAD)    read_cnt++;
        if (oMEM_REQ) req_cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_entry(input logic v, input logic [18:0] a);
        fifo_q.push_back({v, a});
        exp_q.push_back(v ? sram_val(a) : 16'h0000);
    endtask

    task automatic wait_read(input string tag);
        int k;
        k = 0;
        while (!oREAD && k < 100) begin
            tick();
            k++;
        end
        if (!oREAD) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits for all expected pixels, then compares them in order.
    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < exp_q.size() && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() != 0 && exp_q.size() != 0)
            check($sformatf("%s_pix", tag), rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          lat;
        int          r0;
        logic        addr_ok;
        logic        hold_ok;
        logic [18:0] seen_addr;

        // ---------------- reset ----------------
        #12;
        check("reset_outputs", {oREAD, oMEM_REQ, oMEM_ADDR, oPIX_VALID, oPIX_DATA}, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        check("idle_no_read", oREAD, 1'b0);

        // ---------------- 1: valid fetch, immediate grant ----------------
        push_entry(1'b1, 19'd1234);
        wait_read("t1_read");
        lat = 0;
        addr_ok = 1'b0;
        seen_addr = '0;
        while (!oPIX_VALID && lat < 40) begin
            tick();
            lat++;
            if (oMEM_REQ) begin
                addr_ok   = 1'b1;
                seen_addr = oMEM_ADDR;
            end
        end
        // oREAD cycle is one after the IDLE decision: 7 - 1 = 6.
        check("t1_latency", lat, 6);
        check("t1_req_seen", addr_ok, 1'b1);
        check("t1_mem_addr", seen_addr, 19'd1234);
        check("t1_pix", oPIX_DATA, 16'hABCD);
        drain("t1", 50);

        // ---------------- 2: invalid entry -> blank, no SRAM access ----------------
        r0 = req_cyc;
        push_entry(1'b0, 19'd55);
        wait_read("t2_read");
        lat = 0;
        while (!oPIX_VALID && lat < 40) begin
            tick();
            lat++;
        end
        check("t2_latency", lat, 3);
        check("t2_pix", oPIX_DATA, 16'h0000);
        check("t2_no_req", req_cyc - r0, 0);
        drain("t2", 50);

        // ---------------- 3: display stalled, 6 queued ----------------
        iPIX_READY = 1'b0;
        r0 = read_cnt;
        push_entry(1'b1, 19'd100);
        push_entry(1'b1, 19'd101);
        push_entry(1'b0, 19'd102);
        push_entry(1'b1, 19'd103);
        push_entry(1'b1, 19'd104);
        push_entry(1'b1, 19'd105);
        wait_ticks(80);
        check("t3_reads", read_cnt - r0, 4);
        check("t3_no_req", oMEM_REQ, 1'b0);
        check("t3_valid", oPIX_VALID, 1'b1);
        check("t3_head", oPIX_DATA, sram_val(19'd100));
        iPIX_READY = 1'b1;
        drain("t3", 200);

        // ---------------- 4: grant withheld 10 cycles ----------------
        iMEM_GNT = 1'b0;
        push_entry(1'b1, 19'd2000);
        lat = 0;
        while (!oMEM_REQ && lat < 60) begin
            tick();
            lat++;
        end
        check("t4_req", oMEM_REQ, 1'b1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!oMEM_REQ || oMEM_ADDR != 19'd2000) hold_ok = 1'b0;
            tick();
        end
        check("t4_hold", hold_ok, 1'b1);
        iMEM_GNT = 1'b1;
        tick();
        iMEM_GNT = 1'b0;
        check("t4_req_drop", oMEM_REQ, 1'b0);
        lat = 0;
        while (!oPIX_VALID && lat < 40) begin
            tick();
            lat++;
        end
        // Grant cycle g: WAIT g+1..g+2, PUSH g+3, valid g+4.
        check("t4_latency", lat, 3);
        iMEM_GNT = 1'b1;
        drain("t4", 50);

        // ---------------- 5: push coincides with pop at count=3 ----------------
        iPIX_READY = 1'b0;
        push_entry(1'b1, 19'd500);
        push_entry(1'b1, 19'd501);
        push_entry(1'b1, 19'd502);
        wait_ticks(40);
        push_entry(1'b1, 19'd503);
        wait_read("t5_read");
        wait_ticks(5);                 // now in the PUSH cycle of entry 503
        check("t5_valid_at_push", oPIX_VALID, 1'b1);
        iPIX_READY = 1'b1;
        tick();
        iPIX_READY = 1'b0;
        wait_ticks(20);
        check("t5_one_xfer", rx_q.size(), 1);
        // Count 3 leaves room for exactly one more fetch.
        r0 = read_cnt;
        push_entry(1'b1, 19'd504);
        push_entry(1'b1, 19'd505);
        wait_ticks(40);
        check("t5_count3", read_cnt - r0, 1);
        iPIX_READY = 1'b1;
        drain("t5a", 200);

        // Long stream with a stuttering sink wraps the pointers repeatedly.
        for (int i = 0; i < 14; i++)
            push_entry((i % 5) != 2, 19'(600 + i));
        for (int k = 0; k < 600 && rx_q.size() < 14; k++) begin
            iPIX_READY = (k % 3) != 0;
            tick();
        end
        iPIX_READY = 1'b1;
        drain("t5b", 100);

        // ---------------- 6: reset pulsed during WAIT ----------------
        iPIX_READY = 1'b0;
        push_entry(1'b1, 19'd300);
        wait_ticks(20);
        check("t6_pre_valid", oPIX_VALID, 1'b1);
        push_entry(1'b1, 19'd301);
        lat = 0;
        while (!oMEM_REQ && lat < 60) begin
            tick();
            lat++;
        end
        tick();                        // first WAIT cycle
        RESET_N = 1'b0;
        #1;
        check("t6_reset_outputs", {oREAD, oMEM_REQ, oMEM_ADDR, oPIX_VALID, oPIX_DATA}, 0);
        fifo_q.delete();
        exp_q.delete();
        rx_q.delete();
        tick();
        tick();
        RESET_N = 1'b1;
        r0 = read_cnt;
        wait_ticks(6);
        check("t6_empty_after", oPIX_VALID, 1'b0);
        check("t6_no_read", read_cnt - r0, 0);
        iPIX_READY = 1'b1;
        push_entry(1'b1, 19'd302);
        wait_read("t6_read");
        lat = 0;
        while (!oPIX_VALID && lat < 40) begin
            tick();
            lat++;
        end
        check("t6_latency", lat, 6);
        drain("t6", 50);

        check("fifo_underflow", underflow, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
